// File: rtl/led_nios_cpu_oci_dct_packer.sv
// Packs 2-bit trace codes LSB-first into a 30-bit word and hands it to a consumer.
// Optional saturating overflow counter enabled by defining DCT_OVERFLOW_CNT_EN.
module led_nios_cpu_oci_dct_packer #(
  parameter int unsigned THRESHOLD = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [1:0]  code,
  output logic        code_ready,
  input  logic        flush,
  input  logic        test_ending,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_has_ended
`ifdef DCT_OVERFLOW_CNT_EN
  ,
  output logic [7:0]  dct_overflow
`endif
);

  localparam int unsigned BUF_W = 30;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned POS_W = 5;

  typedef enum logic [1:0] {FILL, EMIT, ENDED} state_t;

  state_t             state, state_next;
  logic [BUF_W-1:0]   buf_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               ending, ending_next;
  logic               accept;
  logic [POS_W-1:0]   bit_pos;

  // Next-state, buffer and count update
  always_comb begin
    state_next  = state;
    buf_next    = dct_buffer;
    cnt_next    = dct_count;
    ending_next = ending;
    accept      = 1'b0;
    bit_pos     = {1'b0, dct_count} << 1;
    case (state)
      FILL: begin
        accept      = code_valid && code_ready;
        ending_next = ending | test_ending;
        if (accept) begin
          buf_next = dct_buffer | (BUF_W'(code) << bit_pos);
          cnt_next = dct_count + CNT_W'(1);
        end
        if (accept && (cnt_next == CNT_W'(THRESHOLD))) begin
          state_next = EMIT;
        end else if (flush || ending_next) begin
          // a code accepted alongside the flush makes the word non-empty
          if (cnt_next != '0) state_next = EMIT;
          else if (ending_next) state_next = ENDED;
        end
      end
      EMIT: begin
        ending_next = ending | test_ending;
        if (dct_ready) begin
          buf_next   = '0;
          cnt_next   = '0;
          state_next = ending_next ? ENDED : FILL;
        end
      end
      ENDED: begin
        state_next = ENDED;
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // State, payload and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FILL;
      dct_buffer     <= '0;
      dct_count      <= '0;
      ending         <= 1'b0;
      code_ready     <= 1'b1;
      dct_valid      <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      state          <= state_next;
      dct_buffer     <= buf_next;
      dct_count      <= cnt_next;
      ending         <= ending_next;
      code_ready     <= (state_next == FILL);
      dct_valid      <= (state_next == EMIT);
      test_has_ended <= (state_next == ENDED);
    end
  end

`ifdef DCT_OVERFLOW_CNT_EN
  // Counts cycles where a code was offered but refused; saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      dct_overflow <= '0;
    end else if (code_valid && !code_ready && (dct_overflow != 8'hFF)) begin
      dct_overflow <= dct_overflow + 8'(1);
    end
  end
`endif

endmodule

// File: tb/tb_led_nios_cpu_oci_dct_packer.sv
// Bench for led_nios_cpu_oci_dct_packer: vector table plus hand-written corner sequences.
// Exercises dct_overflow when DCT_OVERFLOW_CNT_EN is defined.
module tb_led_nios_cpu_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        flush;
  logic        test_ending;
  logic        dct_valid;
  logic        dct_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
`ifdef DCT_OVERFLOW_CNT_EN
  logic [7:0]  dct_overflow;
`endif

  led_nios_cpu_oci_dct_packer #(.THRESHOLD(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .code_valid     (code_valid),
    .code           (code),
    .code_ready     (code_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
`ifdef DCT_OVERFLOW_CNT_EN
    ,
    .dct_overflow   (dct_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 = automatic emit at threshold, 1 = flush next cycle, 2 = flush with last code
  typedef struct packed {
    logic [4:0]  ncodes;
    logic [1:0]  mode;
    logic [29:0] seq;
    logic [29:0] exp_buf;
    logic [3:0]  exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [29:0] b;
    logic [3:0]  c;
  } word_t;

  vec_t  vecs [6];
  word_t sb [$];
  int    checks;
  int    errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample handshake at negedge, then advance past the rising edge
  task automatic step();
    word_t w;
    @(negedge clk);
    if (dct_valid && dct_ready && !reset) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got buf=%h cnt=%0d expected no word", dct_buffer, dct_count);
      end else begin
        w = sb.pop_front();
        check("word_buf", 32'(dct_buffer), 32'(w.b));
        check("word_cnt", 32'(dct_count), 32'(w.c));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; code_valid = 1'b0; flush = 1'b0; test_ending = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic send_codes(input int n, input logic [29:0] seq, input logic flush_last);
    for (int i = 0; i < n; i++) begin
      code_valid = 1'b1;
      code       = seq[2*i +: 2];
      flush      = flush_last && (i == n - 1);
      step();
    end
    code_valid = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; code_valid = 1'b0; code = 2'b00; flush = 1'b0;
    test_ending = 1'b0; dct_ready = 1'b0;

    vecs[0] = '{ncodes: 5'd15, mode: 2'd0, seq: 30'h15555555, exp_buf: 30'h15555555, exp_cnt: 4'd15};
    vecs[1] = '{ncodes: 5'd3,  mode: 2'd1, seq: 30'h0000001B, exp_buf: 30'h0000001B, exp_cnt: 4'd3};
    vecs[2] = '{ncodes: 5'd1,  mode: 2'd2, seq: 30'h00000002, exp_buf: 30'h00000002, exp_cnt: 4'd1};
    vecs[3] = '{ncodes: 5'd7,  mode: 2'd1, seq: 30'h00000CCC, exp_buf: 30'h00000CCC, exp_cnt: 4'd7};
    vecs[4] = '{ncodes: 5'd14, mode: 2'd2, seq: 30'h0AAAAAAA, exp_buf: 30'h0AAAAAAA, exp_cnt: 4'd14};
    vecs[5] = '{ncodes: 5'd15, mode: 2'd0, seq: 30'h3FFFFFFF, exp_buf: 30'h3FFFFFFF, exp_cnt: 4'd15};

    do_reset();
    check("rst_code_ready", 32'(code_ready), 32'd1);
    check("rst_dct_valid", 32'(dct_valid), 32'd0);
    check("rst_buf", 32'(dct_buffer), 32'd0);
    check("rst_cnt", 32'(dct_count), 32'd0);
    check("rst_ended", 32'(test_has_ended), 32'd0);

    // Table-driven words with consumer always ready
    dct_ready = 1'b1;
    foreach (vecs[v]) begin
      sb.push_back('{b: vecs[v].exp_buf, c: vecs[v].exp_cnt});
      send_codes(int'(vecs[v].ncodes), vecs[v].seq, vecs[v].mode == 2'd2);
      if (vecs[v].mode == 2'd1) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      check("emit_valid", 32'(dct_valid), 32'd1);
      check("emit_not_ready", 32'(code_ready), 32'd0);
      drain();
      check("after_ready", 32'(code_ready), 32'd1);
      check("after_valid", 32'(dct_valid), 32'd0);
    end

    // Back-pressure: word must hold for 4 cycles
    dct_ready = 1'b0;
    sb.push_back('{b: 30'h1B, c: 4'd3});
    send_codes(3, 30'h1B, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 32'(dct_valid), 32'd1);
      check("hold_buf", 32'(dct_buffer), 32'h1B);
      check("hold_cnt", 32'(dct_count), 32'd3);
      check("hold_code_ready", 32'(code_ready), 32'd0);
      step();
    end
    dct_ready = 1'b1;
    drain();

    // Flush on empty buffer is ignored
    flush = 1'b1; step(); flush = 1'b0;
    check("empty_flush_valid", 32'(dct_valid), 32'd0);
    check("empty_flush_ready", 32'(code_ready), 32'd1);
    step();
    check("empty_flush_valid2", 32'(dct_valid), 32'd0);

    // test_ending arriving while a word waits in EMIT
    dct_ready = 1'b0;
    sb.push_back('{b: 30'h1, c: 4'd1});
    send_codes(1, 30'h1, 1'b1);
    step();
    test_ending = 1'b1; step(); test_ending = 1'b0;
    check("emit_end_valid", 32'(dct_valid), 32'd1);
    dct_ready = 1'b1;
    drain();
    check("emit_end_ended", 32'(test_has_ended), 32'd1);
    check("emit_end_valid_off", 32'(dct_valid), 32'd0);

    // Two codes then test_ending: one word, then sticky end, inputs ignored
    do_reset();
    check("rst2_ended", 32'(test_has_ended), 32'd0);
    sb.push_back('{b: 30'hF, c: 4'd2});
    send_codes(2, 30'hF, 1'b0);
    test_ending = 1'b1; step(); test_ending = 1'b0;
    drain();
    check("end_sticky", 32'(test_has_ended), 32'd1);
    for (int i = 0; i < 5; i++) begin
      code_valid = 1'b1; code = 2'(i); flush = i[0]; test_ending = i[1];
      step();
      check("ended_code_ready", 32'(code_ready), 32'd0);
      check("ended_valid", 32'(dct_valid), 32'd0);
      check("ended_flag", 32'(test_has_ended), 32'd1);
    end
    code_valid = 1'b0; flush = 1'b0; test_ending = 1'b0;

    // test_ending on empty buffer ends immediately without a word
    do_reset();
    test_ending = 1'b1; step(); test_ending = 1'b0;
    check("empty_end_flag", 32'(test_has_ended), 32'd1);
    check("empty_end_valid", 32'(dct_valid), 32'd0);
    step();
    check("empty_end_valid2", 32'(dct_valid), 32'd0);

    // Reset mid-EMIT discards the word even with dct_ready high
    do_reset();
    dct_ready = 1'b0;
    send_codes(2, 30'hA, 1'b1);
    check("pre_rst_valid", 32'(dct_valid), 32'd1);
    reset = 1'b1; dct_ready = 1'b1; code_valid = 1'b1; flush = 1'b1; test_ending = 1'b1;
    step();
    reset = 1'b0; code_valid = 1'b0; flush = 1'b0; test_ending = 1'b0;
    check("midrst_valid", 32'(dct_valid), 32'd0);
    check("midrst_buf", 32'(dct_buffer), 32'd0);
    check("midrst_cnt", 32'(dct_count), 32'd0);
    check("midrst_ready", 32'(code_ready), 32'd1);
    check("midrst_ended", 32'(test_has_ended), 32'd0);
    step();
    check("midrst_valid2", 32'(dct_valid), 32'd0);

`ifdef DCT_OVERFLOW_CNT_EN
    // Refused codes saturate the overflow counter
    do_reset();
    dct_ready = 1'b0;
    send_codes(2, 30'h5, 1'b1);
    for (int i = 0; i < 300; i++) begin
      code_valid = 1'b1;
      step();
    end
    code_valid = 1'b0;
    check("overflow_sat", 32'(dct_overflow), 32'd255);
    do_reset();
    check("overflow_rst", 32'(dct_overflow), 32'd0);
    check("overflow_rst_valid", 32'(dct_valid), 32'd0);
    check("overflow_rst_ready", 32'(code_ready), 32'd1);
    dct_ready = 1'b1;
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
